// File: rtl/gray_pkg.sv
// Shared types for the Gray step monitor.
//   step_t        : classification of a decoded sample against the previous one
//   DEFAULT_WIDTH : default Gray/binary code width
package gray_pkg;

    typedef enum logic [2:0] {
        STEP_FIRST = 3'd0,
        STEP_HOLD  = 3'd1,
        STEP_UP    = 3'd2,
        STEP_DOWN  = 3'd3,
        STEP_JUMP  = 3'd4
    } step_t;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/gray_to_bin.sv
// Purely combinational Gray-to-binary decoder.
//   gray : Gray-coded input (WIDTH bits)
//   bin  : binary equivalent (WIDTH bits)
module gray_to_bin #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // bin[i] is the XOR of all Gray bits from the MSB down to i. Writing it as a
    // reduction avoids the bit-to-bit chain through bin itself.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[WIDTH-1:i];
    end

endmodule

// File: rtl/gray_step_monitor.sv
// Gray step monitor: two-register valid/ready pipeline that decodes Gray
// samples and classifies each step against the previously decoded sample.
//   clk, rst            : clock, synchronous active-high reset
//   gray_in, in_valid   : input sample and its valid
//   in_ready            : input accepted this cycle when high with in_valid
//   bin_out, step       : decoded value and its step classification
//   step_err            : high when step is STEP_JUMP
//   out_valid/out_ready : output handshake
//   err_count           : saturating count of emitted STEP_JUMP results
module gray_step_monitor
    import gray_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     gray_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     bin_out,
    output step_t                step,
    output logic                 step_err,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ERR_CNT_W-1:0] err_count
);

    logic [WIDTH-1:0] s1_gray;
    logic             s1_valid;
    logic [WIDTH-1:0] prev_bin;
    logic             prev_valid;
    logic [WIDTH-1:0] dec_bin;
    step_t            next_step;
    logic             s2_adv;
    logic             s1_adv;
    logic             accept;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = s1_valid && s2_adv;
    assign in_ready = !rst && (!s1_valid || s2_adv);
    assign accept   = in_valid && in_ready;

    gray_to_bin #(
        .WIDTH (WIDTH)
    ) u_dec (
        .gray (s1_gray),
        .bin  (dec_bin)
    );

    // Neighbour compares wrap naturally at WIDTH bits, so max->0 is UP and
    // 0->max is DOWN.
    always_comb begin
        next_step = STEP_JUMP;
        if (!prev_valid) begin
            next_step = STEP_FIRST;
        end else if (dec_bin == prev_bin) begin
            next_step = STEP_HOLD;
        end else if (dec_bin == prev_bin + WIDTH'(1)) begin
            next_step = STEP_UP;
        end else if (dec_bin == prev_bin - WIDTH'(1)) begin
            next_step = STEP_DOWN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_gray    <= '0;
            s1_valid   <= 1'b0;
        end else if (accept) begin
            s1_gray    <= gray_in;
            s1_valid   <= 1'b1;
        end else if (s1_adv) begin
            s1_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_out    <= '0;
            step       <= STEP_FIRST;
            step_err   <= 1'b0;
            out_valid  <= 1'b0;
            prev_bin   <= '0;
            prev_valid <= 1'b0;
        end else if (s1_adv) begin
            bin_out    <= dec_bin;
            step       <= next_step;
            step_err   <= (next_step == STEP_JUMP);
            out_valid  <= 1'b1;
            prev_bin   <= dec_bin;
            prev_valid <= 1'b1;
        end else if (s2_adv) begin
            out_valid  <= 1'b0;
        end
    end

    // Counted on the output handshake so a stalled JUMP is counted once.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (out_valid && out_ready && (step == STEP_JUMP)
                     && (err_count != {ERR_CNT_W{1'b1}})) begin
            err_count <= err_count + ERR_CNT_W'(1);
        end
    end

endmodule

// File: doc/gray_step_monitor.md
Name: gray_step_monitor

Overview:
- Stage directly downstream of the binary-to-Gray converter. Consumes a stream of Gray-coded counter samples over a valid/ready handshake.
- Decodes each sample back to binary and classifies the step from the previously accepted sample as first, hold, up, down or illegal jump.
- Counts illegal multi-bit transitions, for use as a position/pointer sanity checker.

Parameters:
- WIDTH, 4, bit width of the Gray/binary code.
- ERR_CNT_W, 8, width of the saturating illegal-step counter.

Ports:
- clk  input  1  sole clock; all state on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- gray_in  input  WIDTH  Gray-coded sample.
- in_valid  input  1  gray_in is valid.
- in_ready  output  1  block accepts gray_in this cycle.
- bin_out  output  WIDTH  decoded binary value.
- step  output  3  step_t classification of bin_out.
- step_err  output  1  high when step == STEP_JUMP.
- out_valid  output  1  bin_out/step/step_err are valid.
- out_ready  input  1  downstream accepts the output.
- err_count  output  ERR_CNT_W  saturating count of emitted STEP_JUMP results.

Behaviour:
- Interface: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: bin_out=0, step=STEP_FIRST, step_err=0, out_valid=0, err_count=0. Internal s1_valid=0, prev_valid=0.
- in_ready is combinationally 0 while rst is high.
- Two-register pipeline.
  - S1 registers gray_in.
  - S2 holds decoded bin_out/step/step_err and is the output register.
- Advance rules:
  - s2_adv = !out_valid || out_ready.
  - s1_adv = s1_valid && s2_adv.
  - in_ready = !s1_valid || s2_adv.
- Accept occurs when in_valid && in_ready.
  - On accept, S1 loads gray_in.
  - Otherwise, when s1_adv occurs, s1_valid clears.
- On s1_adv, S2 loads:
  - bin = Gray decode of S1: bin[WIDTH-1] = g[WIDTH-1]; bin[i] = bin[i+1] ^ g[i].
  - step computed against prev_bin:
    - !prev_valid gives STEP_FIRST.
    - bin == prev_bin gives STEP_HOLD.
    - bin == prev_bin+1 (mod 2^WIDTH) gives STEP_UP.
    - bin == prev_bin-1 (mod 2^WIDTH) gives STEP_DOWN.
    - else STEP_JUMP.
  - prev_bin then loads bin and prev_valid is set.
- When s2_adv holds with no s1_adv, out_valid clears.
- Wrap-around: max to 0 is STEP_UP and 0 to max is STEP_DOWN (both are single-bit Gray changes).
- Latency: accept in cycle N gives out_valid in cycle N+2 when out_ready is held high. Throughput is 1 sample/cycle.
- Backpressure: S1 and S2 both full with out_ready=0 gives in_ready=0. Holding is lossless and in order, and outputs stay stable while out_valid && !out_ready.
- err_count increments by 1 on each output handshake (out_valid && out_ready) with step==STEP_JUMP. It saturates at 2^ERR_CNT_W-1 and never wraps.
- Simultaneous accept and s1_adv in the same cycle: S2 takes the old S1 contents while S1 takes the new sample.
- Reset mid-operation: all in-flight samples are discarded and history is forgotten. The first sample accepted after reset reports STEP_FIRST.

Decomposition:
- Package gray_pkg holds:
  - typedef enum logic [2:0] step_t {STEP_FIRST=0, STEP_HOLD=1, STEP_UP=2, STEP_DOWN=3, STEP_JUMP=4}
  - localparam DEFAULT_WIDTH=4.
- One sub-module: gray_to_bin, a parameterised purely combinational Gray-to-binary decoder (WIDTH). It is instantiated once between S1 and S2 and is reusable elsewhere.

Test Plan:
- Stream gray 0000,0001,0011,0010 with out_ready=1 -> bin_out 0,1,2,3 and step FIRST,UP,UP,UP. Each result appears 2 cycles after its accept. err_count=0.
- Gray 1000 (bin 15), then 0000, then 1000 -> steps FIRST, UP (bin 0), DOWN (bin 15). step_err stays 0.
- Gray 0000, then 0011 (bin 2), then 0011 -> step FIRST, JUMP with step_err=1 and err_count=1, then HOLD with err_count still 1.
- in_valid held high with incrementing Gray sequence; out_ready=0 for 4 cycles -> exactly 2 samples accepted, in_ready=0 until out_ready returns, outputs stable while stalled. After release, the full sequence emerges in order with no loss or duplication.
- ERR_CNT_W=2, six consecutive jumps (0000,0011,0000,0011,...) consumed -> err_count reads 1,2,3,3,3.
- Assert rst for 1 cycle while S1 and S2 hold valid samples -> next cycle out_valid=0 and err_count=0. The next accepted sample reports STEP_FIRST regardless of the previous value.
